p405s_icu_fill_seq: RTL and testbench
=====================================

P405S_ICU_FILL_SEQ -- requirements
Module: p405s_icu_fill_seq

Interface
REQ-001 Parameter LINE_WORDS, default 8, SHALL set the number of 32-bit words per cache line; only 4 and 8 are legal.
REQ-002 CB  in  1  clock; all state updates on its rising edge.
REQ-003 RST_N  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 MISS_VAL  in  1  miss-capture strobe; accepted only while BUSY=0.
REQ-005 MISS_ADDR  in  [0:31]  miss virtual address, bit 0 = MSB.
REQ-006 ABORT  in  1  flush/cancel of the current fill.
REQ-007 REQ  out  1  fill request to bus, held until ACK.
REQ-008 REQ_ADDR  out  [0:31]  fill start address; stable while REQ=1.
REQ-009 ACK  in  1  bus accepted request.
REQ-010 DVAL  in  1  data beat valid.
REQ-011 DATA  in  [0:31]  beat data.
REQ-012 WR_EN  out  1  array word write strobe.
REQ-013 WR_IDX  out  [0:log2(LINE_WORDS)-1]  word index within line.
REQ-014 WR_DATA  out  [0:31]  array write data.
REQ-015 DONE  out  1  one-cycle fill-complete pulse.
REQ-016 BUSY  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DATA, DRAIN.
REQ-018 IDLE, MISS_VAL=1: capture MISS_ADDR into internal address register, next state REQ; REQ=1 the following cycle.
REQ-019 REQ: hold REQ=1 and REQ_ADDR until ACK=1; on ACK, REQ=0 next cycle, state DATA, beat count cleared.
REQ-020 DATA: each DVAL=1 cycle SHALL produce WR_EN=1 one cycle later with WR_DATA=DATA and WR_IDX=(start index + beat count) mod LINE_WORDS (wrap-around).
REQ-021 After LINE_WORDS beats, DONE SHALL assert in the same cycle as the last WR_EN, and the state SHALL be IDLE (BUSY=0) in that cycle; a MISS_VAL in that cycle SHALL be accepted.
REQ-022 ABORT in REQ without ACK: REQ=0 next cycle, state IDLE, no DONE.
REQ-023 ABORT and ACK in the same cycle: ACK wins the handshake; state DRAIN.
REQ-024 ABORT in DATA: state DRAIN; a beat arriving in the ABORT cycle is still written; later beats are not.
REQ-025 DRAIN: count remaining beats with WR_EN=0; after beat LINE_WORDS, state IDLE, DONE=0.
REQ-026 DVAL in IDLE or REQ SHALL be ignored; MISS_VAL while BUSY=1 SHALL be ignored.
REQ-027 Beat counter width log2(LINE_WORDS)+1; index arithmetic modulo LINE_WORDS, no carry into address.

Reset
REQ-028 RST_N low SHALL force, asynchronously: state IDLE, REQ=0, WR_EN=0, DONE=0, BUSY=0, REQ_ADDR=0, WR_IDX=0, WR_DATA=0, counter=0.
REQ-029 Reset mid-fill SHALL abandon the fill with no DONE; beats after reset release are ignored (state IDLE).

Configuration
REQ-030 Macro P405S_ICU_FILL_CWF_EN defined: critical-word-first; REQ_ADDR = MISS_ADDR with bits [30:31] zero; start index = word-index bits of MISS_ADDR.
REQ-031 Macro undefined: in-order fill; REQ_ADDR line-aligned (word-index and byte bits zero); start index 0.

Structure
REQ-032 Package p405s_icu_pkg SHALL hold the FSM state encoding, LINE_WORDS legal values and the word/byte offset field constants.
REQ-033 Beat counter/index generator SHALL be sub-module p405s_icu_fill_cnt; the remainder stays flat.

Verification
REQ-034 CWF_EN, MISS_ADDR=0x0000_1234, ACK after 2 cycles, 8 consecutive beats D0..D7 -> REQ_ADDR=0x0000_1234, WR_IDX 5,6,7,0,1,2,3,4, DONE with D7.
REQ-035 CWF_EN off, same stimulus -> REQ_ADDR=0x0000_1220, WR_IDX 0..7, DONE with 8th write.
REQ-036 Beats with gaps (DVAL 1,0,1,1,0,...) -> WR_EN only one cycle after each DVAL, idx sequence unchanged.
REQ-037 ABORT with ACK same cycle, then 8 beats -> no WR_EN, no DONE, BUSY=0 after 8th beat.
REQ-038 RST_N low after 3rd beat -> all outputs 0 immediately; subsequent DVAL ignored; new MISS_VAL accepted.
REQ-039 MISS_VAL in DONE cycle with addr 0x0000_2000 -> REQ=1 next cycle, REQ_ADDR=0x0000_2000.

Source files
------------

// File: rtl/p405s_icu_pkg.sv
// Shared definitions for the ICU line-fill sequencer: FSM state encoding,
// legal line sizes and the address offset field geometry.
package p405s_icu_pkg;

  // Fill sequencer states. IDLE must stay at encoding 0 so the reset value
  // and the BUSY decode line up.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } fill_state_e;

  // The only line sizes (in 32-bit words) the sequencer supports.
  localparam int LINE_WORDS_4 = 4;
  localparam int LINE_WORDS_8 = 8;

  // Address geometry: 32-bit addresses, byte offset inside a word is 2 bits,
  // word offset inside the line sits directly above it.
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int BYTE_OFF_LSB = 0;
  localparam int WORD_OFF_LSB = BYTE_OFF_W;

  // Width of the word-offset field for a given line size.
  function automatic int word_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // True when the line size is one the sequencer supports.
  function automatic bit line_words_legal(input int line_words);
    return (line_words == LINE_WORDS_4) || (line_words == LINE_WORDS_8);
  endfunction

endpackage

// File: rtl/p405s_icu_fill_cnt.sv
// Beat counter and write-index generator for the line-fill sequencer.
// Counts accepted beats of the current fill and produces the array word
// index (start index + beat count) modulo the line size; the index never
// carries into the line address.
module p405s_icu_fill_cnt
  import p405s_icu_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  localparam int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,        // restart counting for a new fill
  input  logic             inc,        // one beat accepted this cycle
  input  logic [IDX_W-1:0] start_idx,  // word index of the first beat
  output logic [IDX_W-1:0] idx,        // word index of the current beat
  output logic             last        // current beat is the final one
);

  logic [IDX_W:0] cnt_q;
  logic [IDX_W:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Beat count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Index wraps naturally in IDX_W bits, which is modulo LINE_WORDS.
  assign idx  = start_idx + cnt_q[IDX_W-1:0];
  assign last = (cnt_q == (IDX_W + 1)'(LINE_WORDS - 1));

endmodule

// File: rtl/p405s_icu_fill_seq.sv
// ICU cache-line fill sequencer.
// Captures a miss address, requests the line from the bus, and steers the
// returning data beats into the array with a per-word write strobe.
// Build option: P405S_ICU_FILL_CWF_EN selects critical-word-first (request
// the missed word's address, start writing at its word index); without it
// the fill is in order from a line-aligned address starting at index 0.
//
// Handshake: REQ rises the cycle after a miss is captured and holds, with
// REQ_ADDR stable, until the bus returns ACK=1; REQ drops the following
// cycle. Every cycle with DVAL=1 after ACK is one data beat, there is no
// back-pressure on beats.
module p405s_icu_fill_seq
  import p405s_icu_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic                            CB,
  input  logic                            RST_N,
  input  logic                            MISS_VAL,
  input  logic [0:31]                     MISS_ADDR,
  input  logic                            ABORT,
  output logic                            REQ,
  output logic [0:31]                     REQ_ADDR,
  input  logic                            ACK,
  input  logic                            DVAL,
  input  logic [0:31]                     DATA,
  output logic                            WR_EN,
  output logic [0:$clog2(LINE_WORDS)-1]   WR_IDX,
  output logic [0:31]                     WR_DATA,
  output logic                            DONE,
  output logic                            BUSY,
  output fill_state_e                     dbg_state
);

  localparam int IDX_W = word_off_w(LINE_WORDS);

  // Address bits cleared when forming the fill request address.
  localparam logic [ADDR_W-1:0] BYTE_MASK = (ADDR_W'(1) << BYTE_OFF_W) - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    (ADDR_W'(LINE_WORDS) << BYTE_OFF_W) - ADDR_W'(1);

  if (!line_words_legal(LINE_WORDS)) begin : g_bad_line_words
    $error("p405s_icu_fill_seq: LINE_WORDS must be 4 or 8");
  end

  // Request address derived from the miss address for the selected fill order.
  function automatic logic [ADDR_W-1:0] fill_req_addr(input logic [ADDR_W-1:0] a);
`ifdef P405S_ICU_FILL_CWF_EN
    return a & ~BYTE_MASK;
`else
    return a & ~LINE_MASK;
`endif
  endfunction

  // Value views of the MSB-first buses (numeric value is unchanged).
  logic [ADDR_W-1:0] miss_w;
  logic [DATA_W-1:0] data_w;
  assign miss_w = MISS_ADDR;
  assign data_w = DATA;

  fill_state_e       state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wr_en_q,   wr_en_d;
  logic              done_q,    done_d;
  logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  beat_idx;
  logic              beat_last;

  // The request address already carries the start word index in CWF mode
  // and zeros in in-order mode, so one extraction serves both.
  assign start_idx = addr_q[WORD_OFF_LSB +: IDX_W];

  p405s_icu_fill_cnt #(
    .LINE_WORDS (LINE_WORDS)
  ) u_cnt (
    .clk       (CB),
    .rst_n     (RST_N),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .start_idx (start_idx),
    .idx       (beat_idx),
    .last      (beat_last)
  );

  // Next-state and registered-output logic for the fill FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MISS_VAL) begin
          addr_d  = fill_req_addr(miss_w);
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // A simultaneous ACK completes the handshake even when aborting;
        // the bus will still deliver the line, so it has to be drained.
        if (ACK) begin
          cnt_clr = 1'b1;
          state_d = ABORT ? ST_DRAIN : ST_DATA;
        end else if (ABORT) begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (DVAL) begin
          // A beat arriving together with ABORT is still written.
          wr_en_d   = 1'b1;
          wr_idx_d  = beat_idx;
          wr_data_d = data_w;
          cnt_inc   = 1'b1;
          if (beat_last) begin
            state_d = ST_IDLE;
            done_d  = !ABORT;
          end else if (ABORT) begin
            state_d = ST_DRAIN;
          end
        end else if (ABORT) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Swallow the rest of the line without writing it.
        if (DVAL) begin
          cnt_inc = 1'b1;
          if (beat_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CB or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign REQ       = (state_q == ST_REQ);
  assign BUSY      = (state_q != ST_IDLE);
  assign REQ_ADDR  = addr_q;
  assign WR_EN     = wr_en_q;
  assign WR_IDX    = wr_idx_q;
  assign WR_DATA   = wr_data_q;
  assign DONE      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_p405s_icu_fill_seq.sv
// Directed bench for p405s_icu_fill_seq (LINE_WORDS = 8). Expected values
// follow the P405S_ICU_FILL_CWF_EN build option when it is defined.
module tb_p405s_icu_fill_seq;
  import p405s_icu_pkg::*;

  localparam int LW = 8;
  localparam int IW = 3;
`ifdef P405S_ICU_FILL_CWF_EN
  localparam logic [31:0] A1234_REQ = 32'h0000_1234;
  localparam int          A1234_START = 5;
  localparam logic [31:0] A5678_REQ = 32'h0000_5678;
  localparam int          A5678_START = 6;
`else
  localparam logic [31:0] A1234_REQ = 32'h0000_1220;
  localparam int          A1234_START = 0;
  localparam logic [31:0] A5678_REQ = 32'h0000_5660;
  localparam int          A5678_START = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          CB = 1'b0;
  logic          RST_N;
  logic          MISS_VAL;
  logic [31:0]   MISS_ADDR;
  logic          ABORT;
  logic          REQ;
  logic [31:0]   REQ_ADDR;
  logic          ACK;
  logic          DVAL;
  logic [31:0]   DATA;
  logic          WR_EN;
  logic [IW-1:0] WR_IDX;
  logic [31:0]   WR_DATA;
  logic          DONE;
  logic          BUSY;
  fill_state_e   dbg_state;

  always #5 CB = ~CB;

  p405s_icu_fill_seq #(.LINE_WORDS(LW)) dut (
    .CB        (CB),
    .RST_N     (RST_N),
    .MISS_VAL  (MISS_VAL),
    .MISS_ADDR (MISS_ADDR),
    .ABORT     (ABORT),
    .REQ       (REQ),
    .REQ_ADDR  (REQ_ADDR),
    .ACK       (ACK),
    .DVAL      (DVAL),
    .DATA      (DATA),
    .WR_EN     (WR_EN),
    .WR_IDX    (WR_IDX),
    .WR_DATA   (WR_DATA),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .dbg_state (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard of expected writes: {index, data}.
  logic [IW+31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CB);
    #1;
  endtask

  // Present a miss for one cycle.
  task automatic drive_miss(input logic [31:0] addr);
    MISS_ADDR = addr;
    MISS_VAL  = 1'b1;
    step();
    MISS_VAL  = 1'b0;
    MISS_ADDR = '0;
  endtask

  // Drive ACK for one cycle (optionally with ABORT).
  task automatic drive_ack(input logic with_abort);
    ACK   = 1'b1;
    ABORT = with_abort;
    step();
    ACK   = 1'b0;
    ABORT = 1'b0;
  endtask

  // Drive one cycle of the data bus.
  task automatic drive_beat(input logic valid, input logic [31:0] d);
    DVAL = valid;
    DATA = d;
    step();
    DVAL = 1'b0;
    DATA = '0;
  endtask

  // Load scoreboard with a full line starting at start index.
  task automatic load_line(input int start, input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < LW; i++) begin
      exp_q.push_back({IW'(start + i), base + 32'(i)});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0; MISS_VAL = 1'b0; MISS_ADDR = '0; ABORT = 1'b0;
    ACK = 1'b0; DVAL = 1'b0; DATA = '0;
    #3;
    tests_run++; if (REQ !== 1'b0)      begin tests_failed++; $display("FAIL reset_req: got %b want 0", REQ); end
    tests_run++; if (WR_EN !== 1'b0)    begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", WR_EN); end
    tests_run++; if (DONE !== 1'b0)     begin tests_failed++; $display("FAIL reset_done: got %b want 0", DONE); end
    tests_run++; if (BUSY !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    tests_run++; if (REQ_ADDR !== '0)   begin tests_failed++; $display("FAIL reset_req_addr: got %h want 0", REQ_ADDR); end
    tests_run++; if (WR_IDX !== '0)     begin tests_failed++; $display("FAIL reset_wr_idx: got %0d want 0", WR_IDX); end
    tests_run++; if (WR_DATA !== '0)    begin tests_failed++; $display("FAIL reset_wr_data: got %h want 0", WR_DATA); end
    step();
    RST_N = 1'b1;
    step();
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  // Miss at 0x1234, ACK after two REQ cycles, eight back-to-back beats.
  task automatic test_basic_fill();
    logic [IW+31:0] e;
    load_line(A1234_START, 32'hD000_0000);
    drive_miss(32'h0000_1234);
    tests_run++; if (REQ !== 1'b1)          begin tests_failed++; $display("FAIL basic_req_rise: got %b want 1", REQ); end
    tests_run++; if (REQ_ADDR !== A1234_REQ) begin tests_failed++; $display("FAIL basic_req_addr: got %h want %h", REQ_ADDR, A1234_REQ); end
    tests_run++; if (BUSY !== 1'b1)         begin tests_failed++; $display("FAIL basic_busy: got %b want 1", BUSY); end
    // DVAL while waiting for ACK must not write.
    drive_beat(1'b1, 32'hBAD0_0001);
    tests_run++; if (REQ !== 1'b1 || WR_EN !== 1'b0) begin tests_failed++; $display("FAIL basic_req_hold: got req=%b wr_en=%b want req=1 wr_en=0", REQ, WR_EN); end
    tests_run++; if (REQ_ADDR !== A1234_REQ) begin tests_failed++; $display("FAIL basic_req_addr_stable: got %h want %h", REQ_ADDR, A1234_REQ); end
    drive_ack(1'b0);
    tests_run++; if (REQ !== 1'b0 || dbg_state !== ST_DATA) begin tests_failed++; $display("FAIL basic_ack: got req=%b state=%0d want req=0 state=DATA", REQ, dbg_state); end
    for (int i = 0; i < LW; i++) begin
      drive_beat(1'b1, 32'hD000_0000 + 32'(i));
      e = exp_q.pop_front();
      tests_run++;
      if (WR_EN !== 1'b1 || WR_IDX !== e[IW+31:32] || WR_DATA !== e[31:0]) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got en=%b idx=%0d data=%h want en=1 idx=%0d data=%h", i, WR_EN, WR_IDX, WR_DATA, e[IW+31:32], e[31:0]);
      end
      tests_run++; if (DONE !== (i == LW - 1)) begin tests_failed++; $display("FAIL basic_done%0d: got %b want %b", i, DONE, (i == LW - 1)); end
      tests_run++; if (BUSY !== (i != LW - 1)) begin tests_failed++; $display("FAIL basic_busy%0d: got %b want %b", i, BUSY, (i != LW - 1)); end
    end
    step();
    tests_run++; if (DONE !== 1'b0 || WR_EN !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got done=%b wr_en=%b want 0 0", DONE, WR_EN); end
  endtask

  // Beats with gaps; a miss during the fill must be ignored.
  task automatic test_gapped_beats();
    logic [11:0]    pat = 12'b1111_0010_1101;
    logic [IW+31:0] e;
    int             beats = 0;
    load_line(A5678_START, 32'hC000_0000);
    drive_miss(32'h0000_5678);
    drive_ack(1'b0);
    for (int c = 0; c < 12; c++) begin
      MISS_VAL  = !pat[c];
      MISS_ADDR = 32'hFFFF_FFF0;
      drive_beat(pat[c], 32'hC000_0000 + 32'(beats));
      MISS_VAL  = 1'b0;
      MISS_ADDR = '0;
      tests_run++; if (WR_EN !== pat[c]) begin tests_failed++; $display("FAIL gap_wr_en%0d: got %b want %b", c, WR_EN, pat[c]); end
      if (pat[c]) begin
        e = exp_q.pop_front();
        beats++;
        tests_run++;
        if (WR_IDX !== e[IW+31:32] || WR_DATA !== e[31:0]) begin
          tests_failed++;
          $display("FAIL gap_write%0d: got idx=%0d data=%h want idx=%0d data=%h", beats, WR_IDX, WR_DATA, e[IW+31:32], e[31:0]);
        end
      end
      tests_run++; if (DONE !== (beats == LW && pat[c])) begin tests_failed++; $display("FAIL gap_done%0d: got %b want %b", c, DONE, (beats == LW && pat[c])); end
    end
    tests_run++; if (REQ_ADDR !== A5678_REQ) begin tests_failed++; $display("FAIL gap_busy_miss_ignored: got %h want %h", REQ_ADDR, A5678_REQ); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL gap_end_busy: got %b want 0", BUSY); end
  endtask

  // ABORT together with ACK: whole line drained, nothing written.
  task automatic test_abort_with_ack();
    drive_miss(32'h0000_1234);
    drive_ack(1'b1);
    tests_run++; if (REQ !== 1'b0 || dbg_state !== ST_DRAIN) begin tests_failed++; $display("FAIL abort_ack_state: got req=%b state=%0d want req=0 state=DRAIN", REQ, dbg_state); end
    for (int i = 0; i < LW; i++) begin
      drive_beat(1'b1, 32'hE000_0000 + 32'(i));
      tests_run++; if (WR_EN !== 1'b0 || DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_ack_beat%0d: got wr_en=%b done=%b want 0 0", i, WR_EN, DONE); end
      tests_run++; if (BUSY !== (i != LW - 1)) begin tests_failed++; $display("FAIL abort_ack_busy%0d: got %b want %b", i, BUSY, (i != LW - 1)); end
    end
  endtask

  // ABORT while REQ is waiting: back to IDLE, later DVAL ignored.
  task automatic test_abort_in_req();
    drive_miss(32'h0000_0040);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    tests_run++; if (REQ !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_req: got req=%b busy=%b done=%b want 0 0 0", REQ, BUSY, DONE); end
    drive_beat(1'b1, 32'h1111_1111);
    tests_run++; if (WR_EN !== 1'b0 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL idle_dval_ignored: got wr_en=%b busy=%b want 0 0", WR_EN, BUSY); end
  endtask

  // ABORT with the 4th beat: that beat is written, the rest drained.
  task automatic test_abort_in_data();
    logic [IW+31:0] e;
    load_line(A1234_START, 32'hA000_0000);
    drive_miss(32'h0000_1234);
    drive_ack(1'b0);
    for (int i = 0; i < LW; i++) begin
      ABORT = (i == 3);
      drive_beat(1'b1, 32'hA000_0000 + 32'(i));
      ABORT = 1'b0;
      e = exp_q.pop_front();
      if (i <= 3) begin
        tests_run++;
        if (WR_EN !== 1'b1 || WR_IDX !== e[IW+31:32] || WR_DATA !== e[31:0]) begin
          tests_failed++;
          $display("FAIL abort_data_write%0d: got en=%b idx=%0d data=%h want en=1 idx=%0d data=%h", i, WR_EN, WR_IDX, WR_DATA, e[IW+31:32], e[31:0]);
        end
      end else begin
        tests_run++; if (WR_EN !== 1'b0) begin tests_failed++; $display("FAIL abort_data_drain%0d: got wr_en=%b want 0", i, WR_EN); end
      end
      tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_data_done%0d: got %b want 0", i, DONE); end
    end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL abort_data_end_busy: got %b want 0", BUSY); end
  endtask

  // Reset asserted after the 3rd beat.
  task automatic test_reset_mid_fill();
    drive_miss(32'h0000_1234);
    drive_ack(1'b0);
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 32'h5000_0000 + 32'(i));
    tests_run++; if (WR_EN !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre: got wr_en=%b want 1", WR_EN); end
    RST_N = 1'b0;
    #1;
    tests_run++;
    if (REQ !== 1'b0 || WR_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0 ||
        REQ_ADDR !== '0 || WR_IDX !== '0 || WR_DATA !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got req=%b en=%b done=%b busy=%b addr=%h idx=%0d data=%h want all 0",
               REQ, WR_EN, DONE, BUSY, REQ_ADDR, WR_IDX, WR_DATA);
    end
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b1, 32'h5000_0010 + 32'(i));
      tests_run++; if (WR_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ignore%0d: got en=%b done=%b busy=%b want 0 0 0", i, WR_EN, DONE, BUSY); end
    end
    drive_miss(32'h0000_2000);
    tests_run++; if (REQ !== 1'b1 || REQ_ADDR !== 32'h0000_2000) begin tests_failed++; $display("FAIL rst_mid_new_miss: got req=%b addr=%h want 1 00002000", REQ, REQ_ADDR); end
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
  endtask

  // Miss presented in the DONE cycle is taken immediately.
  task automatic test_back_to_back();
    drive_miss(32'h0000_1234);
    drive_ack(1'b0);
    for (int i = 0; i < LW; i++) drive_beat(1'b1, 32'h7000_0000 + 32'(i));
    tests_run++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin tests_failed++; $display("FAIL b2b_done: got done=%b busy=%b want 1 0", DONE, BUSY); end
    drive_miss(32'h0000_2000);
    tests_run++; if (REQ !== 1'b1 || REQ_ADDR !== 32'h0000_2000) begin tests_failed++; $display("FAIL b2b_req: got req=%b addr=%h want 1 00002000", REQ, REQ_ADDR); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_pulse: got %b want 0", DONE); end
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL b2b_cleanup: got busy=%b want 0", BUSY); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_fill();
    test_gapped_beats();
    test_abort_with_ack();
    test_abort_in_req();
    test_abort_in_data();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time bound in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
